// File: rtl/csr_file.sv
// Machine-mode CSR file: read mux, RW/RS/RC writes, trap entry, mret return and mcycle.
// Trap and mret redirects are registered, so fetch sees a one-cycle pulse after the event edge.
module csr_file #(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] MSTATUS_WMASK = 'h1888,
  parameter logic [XLEN-1:0] MIP_WMASK     = '0,
  parameter bit              VECTORED_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_rdata,
  input  logic [1:0]      csr_wop,
  input  logic [XLEN-1:0] csr_wsrc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv_mode,
  output logic [XLEN-1:0] satp_out,
  output logic [XLEN-1:0] mstatus_out
);

  localparam logic [11:0] ADDR_SATP     = 12'h180;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

  localparam logic [XLEN-1:0] MTVEC_CLR = VECTORED_EN ? XLEN'('h2) : XLEN'('h3);

  logic [1:0]      priv_q;
  logic [XLEN-1:0] satp_q, mstatus_q, mie_q, mtvec_q, mscratch_q;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, mip_q, mcycle_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic [XLEN-1:0] wval;
  logic            wr_en;
  logic [XLEN-1:0] mstatus_trap, mstatus_mret, trap_base, trap_target;

  function automatic logic [XLEN-1:0] csr_op(input logic [1:0] op,
                                             input logic [XLEN-1:0] old,
                                             input logic [XLEN-1:0] src);
    case (op)
      2'b01:   csr_op = src;
      2'b10:   csr_op = old | src;
      2'b11:   csr_op = old & ~src;
      default: csr_op = old;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] mask_merge(input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] nv,
                                                 input logic [XLEN-1:0] mask);
    mask_merge = (old & ~mask) | (nv & mask);
  endfunction

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_SATP:     csr_rdata = satp_q;
      ADDR_MSTATUS:  csr_rdata = mstatus_q;
      ADDR_MIE:      csr_rdata = mie_q;
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MTVAL:    csr_rdata = mtval_q;
      ADDR_MIP:      csr_rdata = mip_q;
      ADDR_MCYCLE:   csr_rdata = mcycle_q;
      default:       csr_rdata = '0;
    endcase
  end

  // Traps and mret pre-empt any CSR write issued in the same cycle.
  always_comb begin
    wval  = csr_op(csr_wop, csr_rdata, csr_wsrc);
    wr_en = (csr_wop != 2'b00) && !trap_valid && !mret_valid;

    mstatus_trap        = mstatus_q;
    mstatus_trap[7]     = mstatus_q[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = priv_q;

    mstatus_mret        = mstatus_q;
    mstatus_mret[3]     = mstatus_q[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b00;

    trap_base   = {mtvec_q[XLEN-1:2], 2'b00};
    trap_target = trap_base;
    if (mtvec_q[0] && trap_cause[XLEN-1])
      trap_target = trap_base + {trap_cause[XLEN-3:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      priv_q           <= 2'b11;
      satp_q           <= '0;
      mstatus_q        <= '0;
      mie_q            <= '0;
      mtvec_q          <= '0;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mip_q            <= '0;
      mcycle_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= 1'b0;
      mcycle_q         <= mcycle_q + XLEN'(1);
      if (trap_valid) begin
        mepc_q           <= trap_pc & ~XLEN'('h3);
        mcause_q         <= trap_cause;
        mtval_q          <= trap_tval;
        mstatus_q        <= mstatus_trap;
        priv_q           <= 2'b11;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= trap_target;
      end else if (mret_valid) begin
        priv_q           <= mstatus_q[12:11];
        mstatus_q        <= mstatus_mret;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= mepc_q;
      end else if (wr_en) begin
        case (csr_addr)
          ADDR_SATP:     satp_q     <= wval;
          ADDR_MSTATUS:  mstatus_q  <= mask_merge(mstatus_q, wval, MSTATUS_WMASK);
          ADDR_MIE:      mie_q      <= wval;
          ADDR_MTVEC:    mtvec_q    <= wval & ~MTVEC_CLR;
          ADDR_MSCRATCH: mscratch_q <= wval;
          ADDR_MEPC:     mepc_q     <= wval & ~XLEN'('h3);
          ADDR_MCAUSE:   mcause_q   <= wval;
          ADDR_MTVAL:    mtval_q    <= wval;
          ADDR_MIP:      mip_q      <= mask_merge(mip_q, wval, MIP_WMASK);
          ADDR_MCYCLE:   mcycle_q   <= wval;
          default:       ;
        endcase
      end
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign priv_mode      = priv_q;
  assign satp_out       = satp_q;
  assign mstatus_out    = mstatus_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset state, write ops and masks, trap/mret flow,
// priority, vectored traps, mcycle wrap and reset-over-trap.
module tb_csr_file;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] ONES = '1;

  logic            clk = 1'b0;
  logic            reset;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_rdata;
  logic [1:0]      csr_wop;
  logic [XLEN-1:0] csr_wsrc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc, trap_cause, trap_tval;
  logic            mret_valid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      priv_mode;
  logic [XLEN-1:0] satp_out, mstatus_out;

  int checks   = 0;
  int failures = 0;

  csr_file dut (
    .clk(clk), .reset(reset),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_wop(csr_wop), .csr_wsrc(csr_wsrc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_tval(trap_tval),
    .mret_valid(mret_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .priv_mode(priv_mode), .satp_out(satp_out), .mstatus_out(mstatus_out)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [XLEN-1:0] src);
    csr_wop  = op;
    csr_addr = addr;
    csr_wsrc = src;
    tick();
    csr_wop  = 2'b00;
    csr_wsrc = '0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [XLEN-1:0] exp);
    csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  logic [11:0] map [10] = '{12'h180, 12'h300, 12'h304, 12'h305, 12'h340,
                            12'h341, 12'h342, 12'h343, 12'h344, 12'hB00};

  initial begin
    reset = 1'b0; csr_addr = '0; csr_wop = 2'b00; csr_wsrc = '0;
    trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0; mret_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;

    chk("rst_priv", XLEN'(priv_mode), 64'h3);
    chk("rst_redir", XLEN'(redirect_valid), 64'h0);
    for (int i = 0; i < 10; i++) rd($sformatf("rst_csr_%0h", map[i]), map[i], 64'h0);

    csr_do(2'b01, 12'h341, 64'h1003);
    rd("mepc_align", 12'h341, 64'h1000);
    csr_do(2'b10, 12'h304, 64'hF0);
    csr_do(2'b11, 12'h304, 64'h30);
    rd("mie_rs_rc", 12'h304, 64'hC0);
    csr_do(2'b10, 12'h304, 64'h0);
    rd("mie_rs_zero", 12'h304, 64'hC0);
    csr_do(2'b11, 12'h304, 64'h0);
    rd("mie_rc_zero", 12'h304, 64'hC0);
    csr_do(2'b01, 12'h300, ONES);
    rd("mstatus_mask", 12'h300, 64'h1888);
    chk("mstatus_out", mstatus_out, 64'h1888);
    csr_do(2'b01, 12'h344, ONES);
    rd("mip_ro", 12'h344, 64'h0);
    csr_do(2'b01, 12'h7C0, 64'h5);
    rd("unmapped", 12'h7C0, 64'h0);
    csr_do(2'b01, 12'h180, 64'h8000_0000_0000_1234);
    chk("satp_out", satp_out, 64'h8000_0000_0000_1234);
    csr_do(2'b01, 12'h305, 64'h1003);
    rd("mtvec_bit1", 12'h305, 64'h1001);

    // Trap from M-mode with MIE=1, then mret back-to-back.
    csr_do(2'b01, 12'h305, 64'h8000_0000);
    csr_do(2'b01, 12'h300, 64'h8);
    trap_valid = 1'b1; trap_pc = 64'h2004; trap_cause = 64'h2; trap_tval = 64'hBAD;
    tick();
    trap_valid = 1'b0;
    chk("trap_rv", XLEN'(redirect_valid), 64'h1);
    chk("trap_pc", redirect_pc, 64'h8000_0000);
    chk("trap_mstatus", mstatus_out, 64'h1880);
    rd("trap_mepc", 12'h341, 64'h2004);
    rd("trap_mcause", 12'h342, 64'h2);
    rd("trap_mtval", 12'h343, 64'hBAD);
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    chk("mret_rv", XLEN'(redirect_valid), 64'h1);
    chk("mret_pc", redirect_pc, 64'h2004);
    chk("mret_priv", XLEN'(priv_mode), 64'h3);
    chk("mret_mstatus", mstatus_out, 64'h88);
    tick();
    chk("pulse_end", XLEN'(redirect_valid), 64'h0);

    // Trap beats a same-cycle write; vectored interrupt target.
    csr_do(2'b01, 12'h340, 64'h11);
    csr_do(2'b01, 12'h305, 64'h1001);
    trap_valid = 1'b1; trap_pc = 64'h3000; trap_cause = 64'h8000_0000_0000_0007; trap_tval = '0;
    csr_wop = 2'b01; csr_addr = 12'h340; csr_wsrc = 64'h55;
    tick();
    trap_valid = 1'b0; csr_wop = 2'b00;
    chk("vec_rv", XLEN'(redirect_valid), 64'h1);
    chk("vec_pc", redirect_pc, 64'h101C);
    rd("prio_mscratch", 12'h340, 64'h11);

    // mret beats a same-cycle write.
    mret_valid = 1'b1; csr_wop = 2'b01; csr_addr = 12'h340; csr_wsrc = 64'h66;
    tick();
    mret_valid = 1'b0; csr_wop = 2'b00;
    chk("mret_prio_pc", redirect_pc, 64'h3000);
    rd("mret_prio_msc", 12'h340, 64'h11);

    csr_do(2'b01, 12'hB00, ONES);
    rd("mcycle_ones", 12'hB00, ONES);
    tick();
    rd("mcycle_wrap", 12'hB00, 64'h0);
    tick();
    rd("mcycle_inc", 12'hB00, 64'h1);

    // Reset wins over a simultaneous trap.
    reset = 1'b0; trap_valid = 1'b1; trap_pc = 64'h4000; trap_cause = 64'h5; trap_tval = 64'h9;
    tick();
    reset = 1'b1; trap_valid = 1'b0;
    chk("rtrap_rv", XLEN'(redirect_valid), 64'h0);
    chk("rtrap_pc", redirect_pc, 64'h0);
    chk("rtrap_priv", XLEN'(priv_mode), 64'h3);
    chk("rtrap_mstatus", mstatus_out, 64'h0);
    chk("rtrap_satp", satp_out, 64'h0);
    rd("rtrap_mepc", 12'h341, 64'h0);
    rd("rtrap_mcause", 12'h342, 64'h0);
    rd("rtrap_mscratch", 12'h340, 64'h0);
    rd("rtrap_mtvec", 12'h305, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
